m_issue_ctrl: RTL and testbench

In-order issue controller between the instruction decoder and the execution units. It accepts one decoded instruction per cycle into a single-entry issue slot. It tracks pending register writes in a 32-bit scoreboard and holds the slot on register hazards or memory back-pressure. It then dispatches the instruction to either the ALU port or the memory port using valid/ready handshakes.

---
 rtl/m_issue_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_m_issue_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/m_issue_ctrl.sv
// m_issue_ctrl -- in-order single-slot issue controller.
//
// Accepts one decoded instruction per cycle into a single issue slot. It tracks
// pending register writes in a 32-bit scoreboard and limits outstanding memory
// operations with a credit counter. It dispatches the slot to the ALU port or
// the memory port using valid/ready handshakes.
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready        decoder handshake; in_ready is combinational
//   in_decoded               decoded instruction (s_decoded)
//   alu_valid/alu_ready      ALU dispatch handshake
//   mem_valid/mem_ready      memory dispatch handshake
//   issue_op                 slot contents, shared by both dispatch ports
//   wb_valid, wb_rd          writeback clears a scoreboard bit
//   mem_done                 one memory operation retired (returns a credit)
//   flush                    discard the slot contents
//   illegal                  one-cycle pulse when a KIND_INVALID op is dropped
//   busy                     scoreboard, bit n = register n has a pending write
//
// Optional build macro MARISCAL_ISSUE_STATS_EN adds:
//   stats_clear              zeroes stall_cycles (wins over increment)
//   stall_cycles             saturating count of cycles spent in WAIT

package m_issue_pkg;

  typedef enum logic [2:0] {
    KIND_INVALID = 3'd0,
    KIND_RRR     = 3'd1,
    KIND_RRI     = 3'd2,
    KIND_MEMORY  = 3'd3,
    KIND_MODEL   = 3'd4,
    KIND_CUSTOM  = 3'd5
  } e_kind;

  typedef struct packed {
    e_kind       kind;
    logic [3:0]  cond;
    logic [3:0]  ctrl;
    logic [4:0]  rd;
    logic [4:0]  rs;
    logic [4:0]  rq;
    logic [15:0] immediate;
    logic [4:0]  shift;
  } s_decoded;

endpackage

module m_issue_ctrl
  import m_issue_pkg::*;
#(
  parameter int unsigned MEM_PENDING_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  s_decoded    in_decoded,
  output logic        alu_valid,
  input  logic        alu_ready,
  output logic        mem_valid,
  input  logic        mem_ready,
  output s_decoded    issue_op,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic        mem_done,
  input  logic        flush,
  output logic        illegal,
  output logic [31:0] busy
`ifdef MARISCAL_ISSUE_STATS_EN
  ,
  input  logic        stats_clear,
  output logic [31:0] stall_cycles
`endif
);

  localparam int unsigned CW = $clog2(MEM_PENDING_MAX + 1);
  localparam logic [CW-1:0] CREDIT_MAX = CW'(MEM_PENDING_MAX);

  typedef enum logic [1:0] {
    S_EMPTY    = 2'd0,
    S_WAIT     = 2'd1,
    S_DISPATCH = 2'd2
  } e_state;

  e_state        state_q, state_nxt;
  logic [CW-1:0] credit_q, credit_nxt, credit_eff;
  logic [31:0]   busy_nxt, busy_eff, set_mask, clr_mask;
  s_decoded      op_nxt;
  logic          alu_hs, mem_hs, hs, port_ready;
  logic          accept, acc_op, acc_illegal, credit_dec;

  // busy[0] is held at zero, so register 0 never raises a hazard.
  function automatic logic blocked(input s_decoded op, input logic [31:0] sb,
                                   input logic [CW-1:0] cr);
    logic haz;
    haz = sb[op.rs] || sb[op.rd] || ((op.kind == KIND_RRR) && sb[op.rq]);
    return haz || ((op.kind == KIND_MEMORY) && (cr == CREDIT_MAX));
  endfunction

  always_comb begin
    alu_hs      = alu_valid && alu_ready;
    mem_hs      = mem_valid && mem_ready;
    hs          = alu_hs || mem_hs;
    port_ready  = (issue_op.kind == KIND_MEMORY) ? mem_ready : alu_ready;
    in_ready    = !flush && ((state_q == S_EMPTY) ||
                             ((state_q == S_DISPATCH) && port_ready));
    accept      = in_valid && in_ready;
    acc_illegal = accept && (in_decoded.kind == KIND_INVALID);
    acc_op      = accept && (in_decoded.kind != KIND_INVALID);
    op_nxt      = acc_op ? in_decoded : issue_op;
  end

  // Scoreboard and credit update. A set and a clear on the same register
  // resolve in favour of the set.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (hs && (issue_op.rd != 5'd0)) set_mask[issue_op.rd] = 1'b1;
    if (wb_valid) clr_mask[wb_rd] = 1'b1;
    busy_nxt = (busy & ~clr_mask) | set_mask;
    busy_nxt[0] = 1'b0;

    credit_dec = mem_done && (credit_q != '0);
    credit_nxt = credit_q;
    if (mem_hs && !credit_dec) credit_nxt = credit_q + CW'(1);
    else if (!mem_hs && credit_dec) credit_nxt = credit_q - CW'(1);
  end

  // An op accepted while the previous one hands off must see that op's
  // scoreboard bit and credit; writebacks and retirements are not bypassed.
  always_comb begin
    busy_eff   = busy | set_mask;
    credit_eff = mem_hs ? credit_q + CW'(1) : credit_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_EMPTY;
    else     state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      S_EMPTY: begin
        if (acc_op)
          state_nxt = blocked(in_decoded, busy_eff, credit_eff) ? S_WAIT : S_DISPATCH;
      end
      S_WAIT: begin
        if (!blocked(issue_op, busy, credit_q)) state_nxt = S_DISPATCH;
      end
      S_DISPATCH: begin
        if (hs) begin
          if (acc_op)
            state_nxt = blocked(in_decoded, busy_eff, credit_eff) ? S_WAIT : S_DISPATCH;
          else
            state_nxt = S_EMPTY;
        end
      end
      default: state_nxt = S_EMPTY;
    endcase
    if (flush) state_nxt = S_EMPTY;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_op  <= '0;
      alu_valid <= 1'b0;
      mem_valid <= 1'b0;
      illegal   <= 1'b0;
      busy      <= '0;
      credit_q  <= '0;
    end else begin
      issue_op  <= op_nxt;
      alu_valid <= (state_nxt == S_DISPATCH) && (op_nxt.kind != KIND_MEMORY);
      mem_valid <= (state_nxt == S_DISPATCH) && (op_nxt.kind == KIND_MEMORY);
      illegal   <= acc_illegal;
      busy      <= busy_nxt;
      credit_q  <= credit_nxt;
    end
  end

`ifdef MARISCAL_ISSUE_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cycles <= '0;
    else if (stats_clear)
      stall_cycles <= '0;
    else if ((state_q == S_WAIT) && (stall_cycles != '1))
      stall_cycles <= stall_cycles + 32'd1;
  end
`endif

endmodule

// File: tb/tb_m_issue_ctrl.sv
module tb_m_issue_ctrl;
  import m_issue_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  s_decoded    in_decoded;
  logic        alu_valid, alu_ready;
  logic        mem_valid, mem_ready;
  s_decoded    issue_op;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        mem_done;
  logic        flush;
  logic        illegal;
  logic [31:0] busy;
`ifdef MARISCAL_ISSUE_STATS_EN
  logic        stats_clear;
  logic [31:0] stall_cycles;
`endif

  int total = 0;
  int bad = 0;

  m_issue_ctrl #(.MEM_PENDING_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_decoded(in_decoded),
    .alu_valid(alu_valid), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .issue_op(issue_op),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .mem_done(mem_done),
    .flush(flush), .illegal(illegal), .busy(busy)
`ifdef MARISCAL_ISSUE_STATS_EN
    , .stats_clear(stats_clear), .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  function automatic s_decoded mk(e_kind k, logic [4:0] rd, logic [4:0] rs,
                                  logic [4:0] rq, logic [15:0] imm);
    s_decoded d;
    d = '0;
    d.kind = k; d.rd = rd; d.rs = rs; d.rq = rq; d.immediate = imm;
    return d;
  endfunction

  task automatic idle_inputs();
    in_valid = 1'b0; in_decoded = '0; alu_ready = 1'b1; mem_ready = 1'b1;
    wb_valid = 1'b0; wb_rd = '0; mem_done = 1'b0; flush = 1'b0;
`ifdef MARISCAL_ISSUE_STATS_EN
    stats_clear = 1'b0;
`endif
  endtask

  task automatic do_reset();
    idle_inputs();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%0b exp=1", in_ready); end
    total++; if (alu_valid !== 1'b0) begin bad++; $display("FAIL rst_alu_valid got=%0b exp=0", alu_valid); end
    total++; if (mem_valid !== 1'b0) begin bad++; $display("FAIL rst_mem_valid got=%0b exp=0", mem_valid); end
    total++; if (illegal !== 1'b0) begin bad++; $display("FAIL rst_illegal got=%0b exp=0", illegal); end
    total++; if (busy !== 32'h0) begin bad++; $display("FAIL rst_busy got=%0h exp=0", busy); end
    total++; if (issue_op !== s_decoded'('0)) begin bad++; $display("FAIL rst_issue_op got=%0h exp=0", issue_op); end
    // asynchronous reset while an op sits in DISPATCH
    alu_ready = 1'b0; in_valid = 1'b1; in_decoded = mk(KIND_RRR, 5'd9, 5'd1, 5'd2, 16'h0009);
    @(negedge clk); in_valid = 1'b0;
    total++; if (alu_valid !== 1'b1) begin bad++; $display("FAIL async_pre_valid got=%0b exp=1", alu_valid); end
    #2 rst = 1'b1; #1;
    total++; if (alu_valid !== 1'b0) begin bad++; $display("FAIL async_alu_valid got=%0b exp=0", alu_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL async_in_ready got=%0b exp=1", in_ready); end
    @(negedge clk); rst = 1'b0; alu_ready = 1'b1;
    @(negedge clk);
    total++; if (busy !== 32'h0) begin bad++; $display("FAIL async_busy got=%0h exp=0", busy); end
  endtask

  task automatic test_hazard();
    do_reset();
    in_valid = 1'b1; in_decoded = mk(KIND_RRR, 5'd3, 5'd1, 5'd2, 16'h0001);
    @(negedge clk); // op1 in DISPATCH
    total++; if (alu_valid !== 1'b1) begin bad++; $display("FAIL haz_op1_valid got=%0b exp=1", alu_valid); end
    total++; if (issue_op.rd !== 5'd3) begin bad++; $display("FAIL haz_op1_rd got=%0d exp=3", issue_op.rd); end
    in_decoded = mk(KIND_RRR, 5'd4, 5'd3, 5'd5, 16'h0002);
    @(negedge clk); in_valid = 1'b0; // op1 dispatched, op2 waiting
    total++; if (alu_valid !== 1'b0) begin bad++; $display("FAIL haz_wait_valid got=%0b exp=0", alu_valid); end
    total++; if (busy !== 32'h8) begin bad++; $display("FAIL haz_busy_r3 got=%0h exp=8", busy); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL haz_in_ready got=%0b exp=0", in_ready); end
    @(negedge clk); @(negedge clk);
    wb_valid = 1'b1; wb_rd = 5'd3; // three cycles after the op1 handshake
    @(negedge clk); wb_valid = 1'b0;
    total++; if (alu_valid !== 1'b0) begin bad++; $display("FAIL haz_wb_plus1 got=%0b exp=0", alu_valid); end
    total++; if (busy !== 32'h0) begin bad++; $display("FAIL haz_busy_clr got=%0h exp=0", busy); end
    @(negedge clk);
    total++; if (alu_valid !== 1'b1) begin bad++; $display("FAIL haz_wb_plus2 got=%0b exp=1", alu_valid); end
    total++; if (issue_op.immediate !== 16'h0002) begin bad++; $display("FAIL haz_op2_imm got=%0h exp=2", issue_op.immediate); end
    @(negedge clk);
    total++; if (busy !== 32'h10) begin bad++; $display("FAIL haz_busy_r4 got=%0h exp=10", busy); end
  endtask

  task automatic test_mem_credit();
    do_reset();
    in_valid = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      in_decoded = mk(KIND_MEMORY, 5'd0, 5'd0, 5'd0, 16'(i));
      @(negedge clk);
      if (i == 5) in_valid = 1'b0;
      if (i <= 4) begin
        total++; if (mem_valid !== 1'b1 || alu_valid !== 1'b0 || issue_op.immediate !== 16'(i)) begin
          bad++; $display("FAIL mem_dispatch%0d got=%0b/%0h exp=1/%0h", i, mem_valid, issue_op.immediate, i);
        end
      end
    end
    // fifth op now held in WAIT at full credit
    total++; if (mem_valid !== 1'b0) begin bad++; $display("FAIL mem_fifth_wait got=%0b exp=0", mem_valid); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL mem_wait_ready got=%0b exp=0", in_ready); end
    @(negedge clk);
    total++; if (mem_valid !== 1'b0) begin bad++; $display("FAIL mem_still_wait got=%0b exp=0", mem_valid); end
    mem_done = 1'b1;
    @(negedge clk); mem_done = 1'b0;
    total++; if (mem_valid !== 1'b0) begin bad++; $display("FAIL mem_done_plus1 got=%0b exp=0", mem_valid); end
    @(negedge clk);
    total++; if (mem_valid !== 1'b1 || issue_op.immediate !== 16'd5) begin
      bad++; $display("FAIL mem_release got=%0b/%0h exp=1/5", mem_valid, issue_op.immediate);
    end
  endtask

  task automatic test_invalid();
    do_reset();
    in_valid = 1'b1; in_decoded = mk(KIND_INVALID, 5'd5, 5'd0, 5'd0, 16'h00EE);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL inv_in_ready got=%0b exp=1", in_ready); end
    @(negedge clk); in_valid = 1'b0;
    total++; if (illegal !== 1'b1) begin bad++; $display("FAIL inv_illegal got=%0b exp=1", illegal); end
    total++; if (alu_valid !== 1'b0 || mem_valid !== 1'b0) begin bad++; $display("FAIL inv_no_dispatch got=%0b%0b exp=00", alu_valid, mem_valid); end
    @(negedge clk);
    total++; if (illegal !== 1'b0) begin bad++; $display("FAIL inv_pulse_end got=%0b exp=0", illegal); end
    total++; if (busy !== 32'h0) begin bad++; $display("FAIL inv_busy got=%0h exp=0", busy); end
  endtask

  task automatic test_flush();
    do_reset();
    flush = 1'b1; #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_empty_ready got=%0b exp=0", in_ready); end
    @(negedge clk); flush = 1'b0;
    alu_ready = 1'b0; in_valid = 1'b1; in_decoded = mk(KIND_RRR, 5'd6, 5'd1, 5'd2, 16'h0006);
    @(negedge clk); in_valid = 1'b0;
    total++; if (alu_valid !== 1'b1) begin bad++; $display("FAIL flush_pre_valid got=%0b exp=1", alu_valid); end
    flush = 1'b1; #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_in_ready got=%0b exp=0", in_ready); end
    @(negedge clk); flush = 1'b0;
    total++; if (alu_valid !== 1'b0) begin bad++; $display("FAIL flush_alu_valid got=%0b exp=0", alu_valid); end
    total++; if (busy !== 32'h0) begin bad++; $display("FAIL flush_busy got=%0h exp=0", busy); end
    // a handshake that completes in the flush cycle still sets the scoreboard
    alu_ready = 1'b1; in_valid = 1'b1; in_decoded = mk(KIND_RRI, 5'd9, 5'd1, 5'd0, 16'h0009);
    @(negedge clk); in_valid = 1'b0; flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    total++; if (busy !== 32'h200) begin bad++; $display("FAIL flush_hs_busy got=%0h exp=200", busy); end
  endtask

  task automatic test_set_wins();
    do_reset();
    in_valid = 1'b1; in_decoded = mk(KIND_RRI, 5'd7, 5'd0, 5'd0, 16'h0007);
    @(negedge clk); in_valid = 1'b0; wb_valid = 1'b1; wb_rd = 5'd7;
    @(negedge clk); wb_valid = 1'b0;
    total++; if (busy !== 32'h80) begin bad++; $display("FAIL setwin_busy got=%0h exp=80", busy); end
    in_valid = 1'b1; in_decoded = mk(KIND_MODEL, 5'd0, 5'd0, 5'd0, 16'h0000);
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk);
    total++; if (busy !== 32'h80) begin bad++; $display("FAIL r0_busy got=%0h exp=80", busy); end
    wb_valid = 1'b1; wb_rd = 5'd12; // writeback to a non-busy register
    @(negedge clk); wb_valid = 1'b0;
    total++; if (busy !== 32'h80) begin bad++; $display("FAIL wb_nonbusy got=%0h exp=80", busy); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_decoded = mk(KIND_CUSTOM, 5'(10 + i), 5'd1, 5'd2, 16'(16'h00A0 + i));
      @(negedge clk);
      total++; if (alu_valid !== 1'b1 || issue_op.immediate !== 16'(16'h00A0 + i)) begin
        bad++; $display("FAIL b2b_op%0d got=%0b/%0h exp=1/%0h", i, alu_valid, issue_op.immediate, 16'h00A0 + i);
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
    total++; if (busy !== 32'h1C00 || alu_valid !== 1'b0) begin
      bad++; $display("FAIL b2b_busy got=%0h/%0b exp=1c00/0", busy, alu_valid);
    end
  endtask

`ifdef MARISCAL_ISSUE_STATS_EN
  task automatic test_stats();
    do_reset();
    in_valid = 1'b1; in_decoded = mk(KIND_RRR, 5'd3, 5'd1, 5'd2, 16'h0001);
    @(negedge clk); in_decoded = mk(KIND_RRR, 5'd4, 5'd3, 5'd0, 16'h0002);
    @(negedge clk); in_valid = 1'b0;
    for (int i = 0; i < 4; i++) @(negedge clk);
    wb_valid = 1'b1; wb_rd = 5'd3;
    @(negedge clk); wb_valid = 1'b0;
    @(negedge clk);
    total++; if (stall_cycles !== 32'd6) begin bad++; $display("FAIL stats_count got=%0d exp=6", stall_cycles); end
    stats_clear = 1'b1;
    @(negedge clk); stats_clear = 1'b0;
    total++; if (stall_cycles !== 32'd0) begin bad++; $display("FAIL stats_clear got=%0d exp=0", stall_cycles); end
  endtask
`endif

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_hazard();
    test_mem_credit();
    test_invalid();
    test_flush();
    test_set_wins();
    test_back_to_back();
`ifdef MARISCAL_ISSUE_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
